// File: rtl/wb_port_arbiter.sv
// Shares the RegFile write port between pipeline writeback (priority) and a queued long-latency unit.
// Optional perf counters are built when WB_ARB_PERF_EN is defined.
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  input  logic        ext_valid,
  output logic        ext_ready,
  input  logic [4:0]  ext_waddr,
  input  logic [31:0] ext_wdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_kill_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);

  typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_FORCE = 1'b1} state_t;

  state_t          state_r, next_state_s;
  logic [WW-1:0]   wait_r, wait_next_s;
  logic [CW-1:0]   count_r;
  logic [AW-1:0]   rd_ptr_r, wr_ptr_r;
  logic [4:0]      addr_r [DEPTH];
  logic [31:0]     data_r [DEPTH];
  logic [DEPTH-1:0] live_r;

  logic            pipe_real_s, head_valid_s, head_live_s, head_killed_s;
  logic            push_s, pop_s, kill_en_s, push_live_s;
  logic [DEPTH-1:0] kill_mask_s;
  logic            rf_wen_s, pipe_stall_s, ext_ready_s;
  logic [4:0]      rf_waddr_s;
  logic [31:0]     rf_wdata_s;

  // Port selection, pop/kill decisions and starvation counter next-state.
  always_comb begin
    rf_wen_s      = 1'b0;
    rf_waddr_s    = 5'd0;
    rf_wdata_s    = 32'd0;
    pipe_stall_s  = 1'b0;
    pop_s         = 1'b0;
    kill_en_s     = 1'b0;
    next_state_s  = state_r;
    wait_next_s   = wait_r;
    pipe_real_s   = pipe_wen && (pipe_waddr != 5'd0);
    head_valid_s  = (count_r != {CW{1'b0}});
    head_live_s   = head_valid_s && live_r[rd_ptr_r];
    head_killed_s = pipe_real_s && (addr_r[rd_ptr_r] == pipe_waddr);
    ext_ready_s   = !rst && (count_r < DEPTH_C);
    push_s        = ext_valid && ext_ready_s;
    if (rst) begin
      next_state_s = ST_NORMAL;
      wait_next_s  = {WW{1'b0}};
    end else begin
      case (state_r)
        ST_NORMAL: begin
          kill_en_s = pipe_real_s;
          if (pipe_real_s) begin
            rf_wen_s   = 1'b1;
            rf_waddr_s = pipe_waddr;
            rf_wdata_s = pipe_wdata;
          end else if (head_live_s) begin
            rf_wen_s   = 1'b1;
            rf_waddr_s = addr_r[rd_ptr_r];
            rf_wdata_s = data_r[rd_ptr_r];
            pop_s      = 1'b1;
          end else begin
            rf_wen_s   = 1'b0;
          end
          // Dead heads are discarded without using the port.
          if (head_valid_s && !live_r[rd_ptr_r]) begin
            pop_s = 1'b1;
          end else begin
            pop_s = pop_s;
          end
        end
        ST_FORCE: begin
          pipe_stall_s = 1'b1;
          rf_wen_s     = head_live_s;
          rf_waddr_s   = addr_r[rd_ptr_r];
          rf_wdata_s   = data_r[rd_ptr_r];
          pop_s        = head_valid_s;
          next_state_s = ST_NORMAL;
        end
        default: begin
          next_state_s = ST_NORMAL;
        end
      endcase

      if (pop_s || !head_valid_s) begin
        wait_next_s = {WW{1'b0}};
      end else if ((state_r == ST_NORMAL) && head_live_s && pipe_real_s) begin
        if ((wait_r + WW'(1)) == MAX_WAIT_C) begin
          wait_next_s = {WW{1'b0}};
          // A head killed by this very write will be dropped next cycle instead.
          next_state_s = head_killed_s ? ST_NORMAL : ST_FORCE;
        end else begin
          wait_next_s = wait_r + WW'(1);
        end
      end else begin
        wait_next_s = wait_r;
      end
    end
  end

  // Entries superseded by an accepted pipeline write to the same register.
  always_comb begin
    logic [AW-1:0] rel;
    kill_mask_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rel = AW'(i) - rd_ptr_r;
      kill_mask_s[i] = kill_en_s && ({1'b0, rel} < count_r) && live_r[i] &&
                       (addr_r[i] == pipe_waddr);
    end
    push_live_s = (ext_waddr != 5'd0) && !(kill_en_s && (ext_waddr == pipe_waddr));
  end

  // FIFO storage, pointers, occupancy and FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_NORMAL;
      wait_r   <= {WW{1'b0}};
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      live_r   <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= 5'd0;
        data_r[i] <= 32'd0;
      end
    end else begin
      state_r <= next_state_s;
      wait_r  <= wait_next_s;
      live_r  <= live_r & ~kill_mask_s;
      if (push_s) begin
        addr_r[wr_ptr_r] <= ext_waddr;
        data_r[wr_ptr_r] <= ext_wdata;
        live_r[wr_ptr_r] <= push_live_s;
        wr_ptr_r         <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rf_wen     = rf_wen_s;
  assign rf_waddr   = rf_waddr_s;
  assign rf_wdata   = rf_wdata_s;
  assign pipe_stall = pipe_stall_s;
  assign ext_ready  = ext_ready_s;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_stall_r, perf_kill_r, kill_num_s;
  logic        push_kill_s;

  // Number of live bits cleared this cycle, including a same-cycle push.
  always_comb begin
    push_kill_s = push_s && kill_en_s && (ext_waddr != 5'd0) && (ext_waddr == pipe_waddr);
    kill_num_s  = 32'(push_kill_s);
    for (int i = 0; i < DEPTH; i++) begin
      kill_num_s = kill_num_s + 32'(kill_mask_s[i]);
    end
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_r <= 32'd0;
      perf_kill_r  <= 32'd0;
    end else begin
      if (state_r == ST_FORCE) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      perf_kill_r <= perf_kill_r + kill_num_s;
    end
  end

  assign perf_stall_cnt = perf_stall_r;
  assign perf_kill_cnt  = perf_kill_r;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_kill_cnt  = 32'd0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=4, MAX_WAIT=8).
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_wen = 1'b0;
  logic [4:0]  pipe_waddr = 5'd0;
  logic [31:0] pipe_wdata = 32'd0;
  logic        pipe_stall;
  logic        ext_valid = 1'b0;
  logic        ext_ready;
  logic [4:0]  ext_waddr = 5'd0;
  logic [31:0] ext_wdata = 32'd0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] perf_stall_cnt, perf_kill_cnt;
  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .perf_stall_cnt(perf_stall_cnt), .perf_kill_cnt(perf_kill_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic ev, input logic [4:0] ea, input logic [31:0] ed);
    pipe_wen = pw; pipe_waddr = pa; pipe_wdata = pd;
    ext_valid = ev; ext_waddr = ea; ext_wdata = ed;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
    #2;
    checks++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || pipe_stall !== 1'b0 || ext_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got wen=%b addr=%0d data=%h stall=%b ready=%b want 0/0/0/0/0", rf_wen, rf_waddr, rf_wdata, pipe_stall, ext_ready);
    end
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_kill_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf got %0d/%0d want 0/0", perf_stall_cnt, perf_kill_cnt);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    checks++;
    if (ext_ready !== 1'b1 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b wen=%b want 1/0", ext_ready, rf_wen);
    end
    tick();
  endtask

  task automatic test_drain;
    do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11);
    #2;
    checks++;
    if (ext_ready !== 1'b1 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL drain_push1 got ready=%b wen=%b want 1/0", ext_ready, rf_wen);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22);
    #2;
    checks++;
    if (ext_ready !== 1'b1 || rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      errors++;
      $display("FAIL drain_r3 got ready=%b wen=%b addr=%0d data=%h want 1/1/3/11", ext_ready, rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin
      errors++;
      $display("FAIL drain_r4 got wen=%b addr=%0d data=%h want 1/4/22", rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    #2;
    checks++;
    if (rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle got wen=%b want 0", rf_wen);
    end
    tick();
  endtask

  task automatic test_force;
    do_reset();
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'hAA);
    #2;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL force_c0 got wen=%b addr=%0d stall=%b want 1/5/0", rf_wen, rf_waddr, pipe_stall);
    end
    tick();
    ext_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #2;
      checks++;
      if (pipe_stall !== 1'b0 || rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55) begin
        errors++;
        $display("FAIL force_blocked c%0d got stall=%b wen=%b addr=%0d data=%h want 0/1/5/55", c, pipe_stall, rf_wen, rf_waddr, rf_wdata);
      end
      tick();
    end
    #2;
    checks++;
    if (pipe_stall !== 1'b1 || rf_wen !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'hAA) begin
      errors++;
      $display("FAIL force_drain got stall=%b wen=%b addr=%0d data=%h want 1/1/6/aa", pipe_stall, rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    #2;
    checks++;
    if (pipe_stall !== 1'b0 || rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55) begin
      errors++;
      $display("FAIL force_resume got stall=%b wen=%b addr=%0d data=%h want 0/1/5/55", pipe_stall, rf_wen, rf_waddr, rf_wdata);
    end
    checks++;
`ifdef WB_ARB_PERF_EN
    if (perf_stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL force_perf got %0d want 1", perf_stall_cnt);
    end
`else
    if (perf_stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL force_perf got %0d want 0", perf_stall_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_kill;
    do_reset();
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd7, 32'h1);
    tick();
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd7, 32'h2);
    tick();
    drive(1'b1, 5'd7, 32'h3, 1'b0, 5'd0, 32'd0);
    #2;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h3) begin
      errors++;
      $display("FAIL kill_pipe got wen=%b addr=%0d data=%h want 1/7/3", rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (rf_wen !== 1'b0) begin
        errors++;
        $display("FAIL kill_dead c%0d got wen=%b addr=%0d data=%h want wen 0", c, rf_wen, rf_waddr, rf_wdata);
      end
      tick();
    end
    checks++;
`ifdef WB_ARB_PERF_EN
    if (perf_kill_cnt !== 32'd2) begin
      errors++;
      $display("FAIL kill_perf got %0d want 2", perf_kill_cnt);
    end
`else
    if (perf_kill_cnt !== 32'd0) begin
      errors++;
      $display("FAIL kill_perf got %0d want 0", perf_kill_cnt);
    end
`endif
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd8, 32'h99);
    #2;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h88) begin
      errors++;
      $display("FAIL kill_same_pipe got wen=%b addr=%0d data=%h want 1/8/88", rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    checks++;
    if (rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL kill_same_push got wen=%b data=%h want wen 0", rf_wen, rf_wdata);
    end
    checks++;
`ifdef WB_ARB_PERF_EN
    if (perf_kill_cnt !== 32'd3) begin
      errors++;
      $display("FAIL kill_perf_same got %0d want 3", perf_kill_cnt);
    end
`else
    if (perf_kill_cnt !== 32'd0) begin
      errors++;
      $display("FAIL kill_perf_same got %0d want 0", perf_kill_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_full;
    logic exp_ready;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd10, 32'h100 + 32'(c));
      #2;
      exp_ready = (c < 4) || (c == 10);
      checks++;
      if (ext_ready !== exp_ready || pipe_stall !== (c == 9)) begin
        errors++;
        $display("FAIL full_flow c%0d got ready=%b stall=%b want %b/%b", c, ext_ready, pipe_stall, exp_ready, (c == 9));
      end
      if (c == 9) begin
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h100) begin
          errors++;
          $display("FAIL full_drain got wen=%b addr=%0d data=%h want 1/10/100", rf_wen, rf_waddr, rf_wdata);
        end
      end else begin
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd5) begin
          errors++;
          $display("FAIL full_pipe c%0d got wen=%b addr=%0d want 1/5", c, rf_wen, rf_waddr);
        end
      end
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_r0;
    do_reset();
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd9, 32'h5);
    tick();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    #2;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h5) begin
      errors++;
      $display("FAIL r0_slot got wen=%b addr=%0d data=%h want 1/9/5", rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    #2;
    checks++;
    if (rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL r0_drop got wen=%b addr=%0d want wen 0", rf_wen, rf_waddr);
    end
    tick();
  endtask

  task automatic test_rst_mid;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd11 + 5'(c), 32'h40 + 32'(c));
      tick();
    end
    drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rf_wen !== 1'b0 || ext_ready !== 1'b0 || pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_now got wen=%b ready=%b stall=%b want 0/0/0", rf_wen, ext_ready, pipe_stall);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (rf_wen !== 1'b0 || ext_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_stale c%0d got wen=%b addr=%0d ready=%b want 0/x/1", c, rf_wen, rf_waddr, ext_ready);
      end
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h77);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd14 || rf_wdata !== 32'h77) begin
      errors++;
      $display("FAIL rstmid_fresh got wen=%b addr=%0d data=%h want 1/14/77", rf_wen, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_drain();
    test_force();
    test_kill();
    test_full();
    test_r0();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single RegFile write port between the in-order pipeline writeback path and a long-latency execution unit (multi-cycle mul/div result return).
- Pipeline writes have priority and pass through with zero latency.
- External results are queued in a small FIFO and drained into free write slots.
- A starvation timer forces a one-cycle pipeline stall so queued results cannot wait forever.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MAX_WAIT, 8, consecutive blocked cycles before a forced drain; >= 1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- pipe_wen  input  1  pipeline writeback enable
- pipe_waddr  input  5  pipeline destination register
- pipe_wdata  input  32  pipeline result
- pipe_stall  output  1  pipeline must hold its writeback values this cycle; they are not consumed
- ext_valid  input  1  external result offered
- ext_ready  output  1  FIFO can accept; transfer when ext_valid && ext_ready
- ext_waddr  input  5  external destination register
- ext_wdata  input  32  external result
- rf_wen  output  1  RegFile write enable
- rf_waddr  output  5  RegFile write address
- rf_wdata  output  32  RegFile write data
- perf_stall_cnt  output  32  forced-stall cycle count (optional feature)
- perf_kill_cnt  output  32  killed-entry count (optional feature)

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; state NORMAL; wait counter 0.
  - rf_wen=0, rf_waddr=0, rf_wdata=0; pipe_stall=0; ext_ready=0 while rst is high; perf counters 0.
- Pipeline write:
  - A pipeline write is real when pipe_wen=1 and pipe_waddr!=0.
  - pipe_wen=1 with pipe_waddr=0 counts as a free slot and is never forwarded.
- Entries:
  - Each FIFO entry holds {addr, data, live}.
  - Push: live=1 unless ext_waddr==0, which pushes live=0.
- Kill rule:
  - On every accepted real pipeline write, all queued entries with a matching addr get live cleared; the newer pipeline value wins.
  - An entry pushed in the same cycle with the same address is also pushed with live=0.
- Outputs are combinational on the current state and inputs, so there is zero added latency.
- NORMAL state:
  - Real pipeline write: rf_* = pipe_*.
  - Otherwise, if the head is live: rf_* = head, pop.
  - Otherwise rf_wen=0, rf_waddr=0, rf_wdata=0.
  - A dead head is popped every cycle regardless of the pipeline, without writing.
- FORCE state (entered only with a live head):
  - pipe_stall=1; rf_* = head; pop; next state NORMAL.
  - The pipeline input is ignored: no write, no kill.
- Wait counter:
  - Increments each NORMAL cycle where a live head exists but a real pipeline write takes the port.
  - Clears on any head pop or when the FIFO is empty.
  - When it would reach MAX_WAIT, the next state is FORCE and the counter clears.
  - MAX_WAIT=1 forces on the first blocked cycle.
- FIFO flow control:
  - ext_ready = (registered count < DEPTH). On full it stays 0 even if a pop happens this cycle; there is no same-cycle push-through.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
- Ordering: external results retire in arrival order. Pipeline writes are never reordered.
- rst asserted mid-operation: queued entries are discarded.

Optional Feature:
- WB_ARB_PERF_EN defined:
  - perf_stall_cnt increments each FORCE cycle.
  - perf_kill_cnt increments per entry whose live bit is cleared by the kill rule, including same-cycle push kills.
  - Both wrap at 2^32.
- Undefined: both ports are driven constant 0 and no counter flops are instantiated.

Test Plan:
- Idle pipe, ext pushes r3=0x11, r4=0x22 on consecutive cycles -> rf writes r3=0x11 then r4=0x22, one cycle after each push; ext_ready stays 1.
- Pipe writes r5 every cycle and ext pushes r6=0xAA, MAX_WAIT=8 -> after 8 blocked cycles a one-cycle pipe_stall=1 with rf write r6=0xAA; the pipe r5 value is held and written the following cycle.
- Push r7=0x1 and r7=0x2, then pipe writes r7=0x3 while blocked -> both entries killed; RegFile sees only r7=0x3; perf_kill_cnt=2 with WB_ARB_PERF_EN.
- Continuous pipe writes, DEPTH=4, ext_valid held high -> exactly 4 accepted, then ext_ready=0 until a forced drain pops, then ext_ready=1 on the next cycle.
- Pipe writes r0 with ext entry r9=0x5 queued -> rf writes r9=0x5 that cycle; r0 never appears on rf_wen.
- Assert rst mid-queue with 3 entries -> rf_wen=0, ext_ready=0 immediately; after release the FIFO is empty and no stale writes occur.
